// File: rtl/shift_pkg.sv
// Shared types and widths for the shift issue stage and its command FIFO.
package shift_pkg;

    localparam int DATA_W = 32;
    localparam int AMT_W  = 5;

    typedef enum logic [1:0] {
        SHIFT_LSL = 2'b00,
        SHIFT_LSR = 2'b01,
        SHIFT_ASR = 2'b10,
        SHIFT_ILL = 2'b11
    } shift_op_e;

    typedef struct packed {
        shift_op_e          op;
        logic [AMT_W-1:0]   amt;
        logic [DATA_W-1:0]  data;
    } shift_cmd_t;

endpackage

// File: rtl/shift_cmd_fifo.sv
// First-word fall-through command FIFO; push is ignored when full, pop when empty.
module shift_cmd_fifo
    import shift_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       flush,
    input  logic       push,
    input  shift_cmd_t push_cmd,
    input  logic       pop,
    output shift_cmd_t head,
    output logic       full,
    output logic       empty
);

    localparam int PTR_W = $clog2(DEPTH);

    shift_cmd_t         mem_q [DEPTH];
    logic [PTR_W:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]     rd_ptr_q, rd_ptr_d;
    logic               do_push, do_pop;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                     (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem_q[rd_ptr_q[PTR_W-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem_q[wr_ptr_q[PTR_W-1:0]] <= push_cmd;
    end

endmodule

// File: rtl/shift_issue_stage.sv
// Flow-controlled issue stage wrapping a combinational 32-bit shifter.
// Optional perf counters enabled by defining SHIFT_ISSUE_PERF_EN.
module shift_issue_stage
    import shift_pkg::*;
#(
    parameter int DATA_W     = shift_pkg::DATA_W,
    parameter int AMT_W      = shift_pkg::AMT_W,
    parameter int FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [AMT_W-1:0]  cmd_amt,
    input  logic [DATA_W-1:0] cmd_data,
    output logic [DATA_W-1:0] shf_in,
    output logic [AMT_W-1:0]  shf_amt,
    output logic              shf_lsl,
    output logic              shf_lsr,
    output logic              shf_asr,
    input  logic [DATA_W-1:0] shf_out,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic [31:0]       perf_issued,
    output logic [31:0]       perf_stall
);

    shift_cmd_t        push_cmd, head;
    logic              fifo_full, fifo_empty, fifo_pop;
    logic              slot_v_q, slot_v_d;
    shift_cmd_t        slot_cmd_q, slot_cmd_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic              rsp_err_q, rsp_err_d;
    logic              rsp_adv, slot_load, slot_ill;

    assign push_cmd  = '{op: shift_op_e'(cmd_op), amt: cmd_amt, data: cmd_data};
    assign cmd_ready = !fifo_full;
    assign rsp_adv   = !rsp_valid_q || rsp_ready;
    assign slot_load = !slot_v_q || rsp_adv;
    assign fifo_pop  = slot_load;

    shift_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .push     (cmd_valid),
        .push_cmd (push_cmd),
        .pop      (fifo_pop),
        .head     (head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign slot_ill = (slot_cmd_q.op == SHIFT_ILL);

    always_comb begin
        slot_v_d    = slot_v_q;
        slot_cmd_d  = slot_cmd_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        if (slot_load) begin
            slot_v_d = !fifo_empty;
            if (!fifo_empty) slot_cmd_d = head;
        end
        if (rsp_adv) begin
            rsp_valid_d = slot_v_q;
            if (slot_v_q) begin
                // Illegal ops bypass the shifter and return the operand untouched.
                rsp_data_d = slot_ill ? slot_cmd_q.data : shf_out;
                rsp_err_d  = slot_ill;
            end
        end
        if (flush) begin
            slot_v_d    = 1'b0;
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_v_q    <= 1'b0;
            slot_cmd_q  <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            slot_v_q    <= slot_v_d;
            slot_cmd_q  <= slot_cmd_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign shf_in    = slot_cmd_q.data;
    assign shf_amt   = slot_cmd_q.amt;
    assign shf_lsl   = slot_v_q && (slot_cmd_q.op == SHIFT_LSL);
    assign shf_lsr   = slot_v_q && (slot_cmd_q.op == SHIFT_LSR);
    assign shf_asr   = slot_v_q && (slot_cmd_q.op == SHIFT_ASR);
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;

`ifdef SHIFT_ISSUE_PERF_EN
    logic [31:0] perf_issued_q, perf_stall_q;

    // Counters survive flush so software sees lifetime totals.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_issued_q <= '0;
            perf_stall_q  <= '0;
        end else begin
            if (rsp_valid_q && rsp_ready)  perf_issued_q <= perf_issued_q + 32'd1;
            if (rsp_valid_q && !rsp_ready) perf_stall_q  <= perf_stall_q + 32'd1;
        end
    end

    assign perf_issued = perf_issued_q;
    assign perf_stall  = perf_stall_q;
`else
    assign perf_issued = '0;
    assign perf_stall  = '0;
`endif

endmodule

// File: tb/tb_shift_issue_stage.sv
// Directed bench for shift_issue_stage with a behavioural shifter model on shf_out.
module tb_shift_issue_stage;

    logic        clk = 1'b0;
    logic        rst_n, flush, cmd_valid, cmd_ready;
    logic [1:0]  cmd_op;
    logic [4:0]  cmd_amt, shf_amt;
    logic [31:0] cmd_data, shf_in, shf_out, rsp_data, perf_issued, perf_stall;
    logic        shf_lsl, shf_lsr, shf_asr, rsp_valid, rsp_ready, rsp_err;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    // Bare shifter: produces 0 when no control is asserted.
    always_comb begin
        shf_out = 32'h0;
        if (shf_lsl)      shf_out = shf_in << shf_amt;
        else if (shf_lsr) shf_out = shf_in >> shf_amt;
        else if (shf_asr) shf_out = 32'($signed(shf_in) >>> shf_amt);
    end

    shift_issue_stage dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_amt     (cmd_amt),
        .cmd_data    (cmd_data),
        .shf_in      (shf_in),
        .shf_amt     (shf_amt),
        .shf_lsl     (shf_lsl),
        .shf_lsr     (shf_lsr),
        .shf_asr     (shf_asr),
        .shf_out     (shf_out),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_data    (rsp_data),
        .rsp_err     (rsp_err),
        .perf_issued (perf_issued),
        .perf_stall  (perf_stall)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_cmd(input logic [1:0] op, input logic [4:0] amt, input logic [31:0] data);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_amt   = amt;
        cmd_data  = data;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_rsp(input string tag);
        int n = 0;
        while (!rsp_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_timeout"}, 64'(rsp_valid), 64'd1);
    endtask

    logic [2:0] ctl;

    initial begin
        rst_n = 1'b0; flush = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00;
        cmd_amt = '0; cmd_data = '0; rsp_ready = 1'b1;
        @(negedge clk);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_rsp_data",  64'(rsp_data),  64'd0);
        check("rst_rsp_err",   64'(rsp_err),   64'd0);
        check("rst_shf_ctl",   64'({shf_lsl, shf_lsr, shf_asr}), 64'd0);
        check("rst_shf_in",    64'(shf_in), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_cmd_ready", 64'(cmd_ready), 64'd1);

        // LSL with latency check
        set_cmd(2'b00, 5'd2, 32'hA5A5A5A5);
        @(negedge clk);
        cmd_valid = 1'b0;
        check("lsl_k_ctl", 64'({shf_lsl, shf_lsr, shf_asr}), 64'd0);
        check("lsl_k_rv",  64'(rsp_valid), 64'd0);
        @(negedge clk);
        check("lsl_k1_ctl", 64'({shf_lsl, shf_lsr, shf_asr}), 64'b100);
        check("lsl_k1_in",  64'(shf_in), 64'hA5A5A5A5);
        check("lsl_k1_amt", 64'(shf_amt), 64'd2);
        check("lsl_k1_rv",  64'(rsp_valid), 64'd0);
        @(negedge clk);
        check("lsl_k2_rv",   64'(rsp_valid), 64'd1);
        check("lsl_k2_data", 64'(rsp_data), 64'h96969694);
        check("lsl_k2_err",  64'(rsp_err), 64'd0);
        check("lsl_k2_ctl",  64'({shf_lsl, shf_lsr, shf_asr}), 64'd0);
        check("lsl_k2_in_hold", 64'(shf_in), 64'hA5A5A5A5);
        @(negedge clk);
        check("lsl_drained", 64'(rsp_valid), 64'd0);

        // LSR then ASR back-to-back
        set_cmd(2'b01, 5'd2, 32'hA5A5A5A5);
        @(negedge clk);
        set_cmd(2'b10, 5'd2, 32'hA5A5A5A5);
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        check("b2b_rv0", 64'(rsp_valid), 64'd1);
        check("b2b_lsr", 64'(rsp_data), 64'h29696969);
        @(negedge clk);
        check("b2b_rv1", 64'(rsp_valid), 64'd1);
        check("b2b_asr", 64'(rsp_data), 64'hE9696969);
        @(negedge clk);
        check("b2b_idle", 64'(rsp_valid), 64'd0);

        // Boundaries: amount 0 and ASR by 31
        set_cmd(2'b00, 5'd0, 32'h00001234);
        @(negedge clk);
        set_cmd(2'b10, 5'd31, 32'h80000000);
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        check("amt0_data", 64'(rsp_data), 64'h00001234);
        @(negedge clk);
        check("asr31_data", 64'(rsp_data), 64'hFFFFFFFF);
        @(negedge clk);

        // Illegal op: controls must stay low throughout
        ctl = 3'b000;
        set_cmd(2'b11, 5'd4, 32'h12345678);
        @(negedge clk);
        cmd_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            ctl = ctl | {shf_lsl, shf_lsr, shf_asr};
            @(negedge clk);
        end
        check("ill_ctl", 64'(ctl), 64'd0);
        check("ill_rv",   64'(rsp_valid), 64'd1);
        check("ill_data", 64'(rsp_data), 64'h12345678);
        check("ill_err",  64'(rsp_err), 64'd1);
        @(negedge clk);

        // Backpressure: fill result, slot and FIFO
        rsp_ready = 1'b0;
        set_cmd(2'b00, 5'd1, 32'h00000001);
        @(negedge clk);
        set_cmd(2'b01, 5'd1, 32'h00000008);
        @(negedge clk);
        set_cmd(2'b10, 5'd4, 32'h80000000);
        @(negedge clk);
        set_cmd(2'b11, 5'd3, 32'hCAFE0000);
        @(negedge clk);
        check("bp_full_ready", 64'(cmd_ready), 64'd0);
        check("bp_rv",   64'(rsp_valid), 64'd1);
        check("bp_data", 64'(rsp_data), 64'h2);
        check("bp_slot", 64'({shf_lsl, shf_lsr, shf_asr}), 64'b010);
        set_cmd(2'b00, 5'd0, 32'hDEADBEEF);
        @(negedge clk);
        cmd_valid = 1'b0;
        check("bp_ready5", 64'(cmd_ready), 64'd0);
        check("bp_hold_data", 64'(rsp_data), 64'h2);
        check("bp_hold_err",  64'(rsp_err), 64'd0);
        rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_d1", 64'(rsp_data), 64'h4);
        @(negedge clk);
        check("bp_d2", 64'(rsp_data), 64'hF8000000);
        @(negedge clk);
        check("bp_d3", 64'({rsp_err, rsp_data}), {31'd0, 1'b1, 32'hCAFE0000});
        @(negedge clk);
        check("bp_no5th", 64'(rsp_valid), 64'd0);

        // Flush with pipe full; the command offered alongside is dropped
        rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_cmd(2'b00, 5'(i), 32'h1);
            @(negedge clk);
        end
        flush = 1'b1;
        set_cmd(2'b01, 5'd1, 32'h0000F000);
        check("fl_pre_ready", 64'(cmd_ready), 64'd0);
        @(negedge clk);
        flush = 1'b0;
        cmd_valid = 1'b0;
        check("fl_rv",    64'(rsp_valid), 64'd0);
        check("fl_ready", 64'(cmd_ready), 64'd1);
        check("fl_ctl",   64'({shf_lsl, shf_lsr, shf_asr}), 64'd0);
        // Flush on an empty pipe while offering a command (ready=1): still dropped
        flush = 1'b1;
        set_cmd(2'b00, 5'd1, 32'h00000003);
        @(negedge clk);
        flush = 1'b0;
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        ctl = 3'b000;
        for (int i = 0; i < 4; i++) begin
            ctl[0] = ctl[0] | rsp_valid;
            @(negedge clk);
        end
        check("fl_no_stale", 64'(ctl), 64'd0);

        // Perf counters: 3 responses, 5 stall cycles
        do_reset();
        rsp_ready = 1'b0;
        set_cmd(2'b00, 5'd1, 32'h1);
        @(negedge clk);
        set_cmd(2'b00, 5'd2, 32'h1);
        @(negedge clk);
        set_cmd(2'b00, 5'd3, 32'h1);
        @(negedge clk);
        cmd_valid = 1'b0;
        wait_rsp("perf");
        repeat (5) @(negedge clk);
        rsp_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("perf_drained", 64'(rsp_valid), 64'd0);
`ifdef SHIFT_ISSUE_PERF_EN
        check("perf_issued", 64'(perf_issued), 64'd3);
        check("perf_stall",  64'(perf_stall),  64'd5);
`else
        check("perf_issued_off", 64'(perf_issued), 64'd0);
        check("perf_stall_off",  64'(perf_stall),  64'd0);
`endif
        rst_n = 1'b0;
        @(negedge clk);
        check("perf_rst", 64'({perf_issued, perf_stall}), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
